mem_line_burst_adapter: RTL and testbench

- Sits directly downstream of the cache controller's memory interface.
- Converts one full-line request into a burst on a narrower memory bus: one command handshake, then LINE_BITS/BUS_WIDTH data beats.
  - A line read (fetch) returns the assembled line.
  - A line write (writeback) serialises the dirty line.
- Presents the level-request / single-cycle-ready protocol the cache controller expects.

---
 rtl/mem_bus_pkg.sv | 34 +++
 rtl/line_serdes.sv | 83 ++++++++
 rtl/mem_line_burst_adapter.sv | 177 +++++++++++++++++
 tb/tb_mem_line_burst_adapter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the cache-side memory burst path: burst FSM
// states, line/bus geometry defaults and the op type used by the cache
// controller. The optional stall timeout is controlled by MEM_TIMEOUT_EN.
package mem_bus_pkg;

   localparam int DEF_ADDR_WIDTH     = 32;
   localparam int DEF_LINE_SIZE      = 64;
   localparam int DEF_BUS_WIDTH      = 32;
   localparam int DEF_TIMEOUT_CYCLES = 256;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_WDATA = 3'd2,
      ST_RDATA = 3'd3,
      ST_DONE  = 3'd4
   } burst_state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } mem_op_e;

   // Line width in bits for a line size given in bytes.
   function automatic int line_bits(input int line_size);
      return line_size * 8;
   endfunction

   // Number of bus beats needed to move one line.
   function automatic int calc_beats(input int line_size, input int bus_width);
      return line_bits(line_size) / bus_width;
   endfunction

endpackage

// File: rtl/line_serdes.sv
// Line datapath for the burst adapter: holds the writeback line and presents
// the current beat, assembles fetched beats into the read line, and keeps the
// beat counter. Sequencing is decided by the adapter FSM.
module line_serdes #(
   parameter int LINE_BITS = 512,
   parameter int BUS_WIDTH = 32,
   parameter int BEATS     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic [LINE_BITS-1:0] wline_i,
   input  logic                 clr_i,
   input  logic                 wbeat_i,
   input  logic                 rbeat_i,
   input  logic [BUS_WIDTH-1:0] rdata_i,
   output logic [BUS_WIDTH-1:0] wdata_o,
   output logic [LINE_BITS-1:0] rline_o,
   output logic                 last_o
);

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic [LINE_BITS-1:0] wline_q;
   logic [BUS_WIDTH-1:0] wword [BEATS];

   // Beat counter: cleared at command acceptance, advanced per accepted beat.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (wbeat_i || rbeat_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Writeback line is captured once when the request is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wline_q <= '0;
      end else if (load_i) begin
         wline_q <= wline_i;
      end
   end

   // Last beat is detected by compare so the counter never relies on wrap.
   assign last_o = (cnt_q == CNT_W'(BEATS - 1));

   genvar gi;
   generate
      for (gi = 0; gi < BEATS; gi++) begin : g_beat
         logic [BUS_WIDTH-1:0] word_q;

         assign wword[gi] = wline_q[gi*BUS_WIDTH +: BUS_WIDTH];

         // Read word gi is written only when the counter points at it.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               word_q <= '0;
            end else if (rbeat_i && (cnt_q == CNT_W'(gi))) begin
               word_q <= rdata_i;
            end
         end

         assign rline_o[gi*BUS_WIDTH +: BUS_WIDTH] = word_q;
      end
   endgenerate

   // Beat 0 is the least-significant word of the line.
   assign wdata_o = wword[cnt_q];

endmodule

// File: rtl/mem_line_burst_adapter.sv
// Converts a full-line fetch/writeback request from the cache controller into
// one command handshake followed by BEATS data beats on the memory bus.
// Optional stall timeout with error completion: define MEM_TIMEOUT_EN.
module mem_line_burst_adapter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int LINE_SIZE      = DEF_LINE_SIZE,
   parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
   parameter int BEATS          = calc_beats(DEF_LINE_SIZE, DEF_BUS_WIDTH),
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_WIDTH-1:0]  line_addr,
   input  logic [LINE_SIZE*8-1:0] line_wdata,
   input  logic                   line_rd_req,
   input  logic                   line_wr_req,
   output logic [LINE_SIZE*8-1:0] line_rdata,
   output logic                   line_ready,
   output logic                   line_err,
   output logic                   cmd_valid,
   input  logic                   cmd_ready,
   output logic                   cmd_write,
   output logic [ADDR_WIDTH-1:0]  cmd_addr,
   output logic                   wvalid,
   input  logic                   wready,
   output logic [BUS_WIDTH-1:0]   wdata,
   input  logic                   rvalid,
   input  logic [BUS_WIDTH-1:0]   rdata
);

   localparam int LINE_BITS = line_bits(LINE_SIZE);

   // Reject geometries the datapath cannot represent.
   generate
      if ((LINE_BITS % BUS_WIDTH) != 0 || BEATS != calc_beats(LINE_SIZE, BUS_WIDTH)
          || TIMEOUT_CYCLES < 2) begin : g_param_err
         $error("mem_line_burst_adapter: unsupported parameter combination");
      end
   endgenerate

   burst_state_e          state_q;
   mem_op_e               op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  cmd_valid_q;
   logic                  wvalid_q;
   logic                  line_ready_q;
   logic                  last_beat;
   logic                  load_line;
   logic                  clr_cnt;
   logic                  wbeat;
   logic                  rbeat;

   assign load_line = (state_q == ST_IDLE) && line_wr_req;
   assign clr_cnt   = (state_q == ST_CMD) && cmd_ready;
   assign wbeat     = (state_q == ST_WDATA) && wready;
   assign rbeat     = (state_q == ST_RDATA) && rvalid;

   line_serdes #(
      .LINE_BITS (LINE_BITS),
      .BUS_WIDTH (BUS_WIDTH),
      .BEATS     (BEATS)
   ) u_serdes (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load_line),
      .wline_i (line_wdata),
      .clr_i   (clr_cnt),
      .wbeat_i (wbeat),
      .rbeat_i (rbeat),
      .rdata_i (rdata),
      .wdata_o (wdata),
      .rline_o (line_rdata),
      .last_o  (last_beat)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int STALL_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [STALL_W-1:0] stall_q;
   logic               line_err_q;
   logic               any_hs;
   logic               in_burst;

   assign any_hs   = (cmd_valid_q && cmd_ready) || (wvalid_q && wready) || rbeat;
   assign in_burst = (state_q == ST_CMD) || (state_q == ST_WDATA) || (state_q == ST_RDATA);
   assign line_err = line_err_q;
`else
   assign line_err = 1'b0;
`endif

   // Burst sequencer with registered handshake and completion outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_READ;
         addr_q       <= '0;
         cmd_valid_q  <= 1'b0;
         wvalid_q     <= 1'b0;
         line_ready_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         stall_q      <= '0;
         line_err_q   <= 1'b0;
`endif
      end else begin
         line_ready_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // Writeback wins when both requests are raised together.
               if (line_wr_req || line_rd_req) begin
                  op_q        <= line_wr_req ? OP_WRITE : OP_READ;
                  addr_q      <= line_addr & ~ADDR_WIDTH'(LINE_SIZE - 1);
                  cmd_valid_q <= 1'b1;
                  state_q     <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  if (op_q == OP_WRITE) begin
                     wvalid_q <= 1'b1;
                     state_q  <= ST_WDATA;
                  end else begin
                     state_q  <= ST_RDATA;
                  end
               end
            end
            ST_WDATA: begin
               if (wready && last_beat) begin
                  wvalid_q     <= 1'b0;
                  line_ready_q <= 1'b1;
                  state_q      <= ST_DONE;
               end
            end
            ST_RDATA: begin
               if (rvalid && last_beat) begin
                  line_ready_q <= 1'b1;
                  state_q      <= ST_DONE;
               end
            end
            ST_DONE: begin
               // No request sampling here; IDLE sees the next one a cycle later.
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
`ifdef MEM_TIMEOUT_EN
         // Stall watchdog overrides the normal sequencing when it expires.
         line_err_q <= 1'b0;
         if ((state_q == ST_IDLE) || any_hs) begin
            stall_q <= '0;
         end else if (in_burst) begin
            if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
               stall_q      <= '0;
               cmd_valid_q  <= 1'b0;
               wvalid_q     <= 1'b0;
               line_ready_q <= 1'b1;
               line_err_q   <= 1'b1;
               state_q      <= ST_DONE;
            end else begin
               stall_q <= stall_q + 1'b1;
            end
         end
`endif
      end
   end

   assign line_ready = line_ready_q;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_write  = (op_q == OP_WRITE);
   assign cmd_addr   = addr_q;
   assign wvalid     = wvalid_q;

endmodule

// File: tb/tb_mem_line_burst_adapter.sv
// Self-checking bench for mem_line_burst_adapter. The bench plays the memory
// slave and predicts every burst from the request alone: command fields,
// beat order, completion timing and the assembled read line.
module tb_mem_line_burst_adapter;

   localparam int AW = 32;
   localparam int LS = 64;
   localparam int LB = LS * 8;
   localparam int BW = 32;
   localparam int NB = LB / BW;
`ifdef MEM_TIMEOUT_EN
   localparam int TO_CYC   = 8;
   localparam int TO_MODEL = 8;
`else
   localparam int TO_CYC   = 256;
   localparam int TO_MODEL = 1 << 30;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] line_addr = '0;
   logic [LB-1:0] line_wdata = '0;
   logic          line_rd_req = 1'b0;
   logic          line_wr_req = 1'b0;
   logic [LB-1:0] line_rdata;
   logic          line_ready;
   logic          line_err;
   logic          cmd_valid;
   logic          cmd_ready = 1'b0;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic          wvalid;
   logic          wready = 1'b0;
   logic [BW-1:0] wdata;
   logic          rvalid = 1'b0;
   logic [BW-1:0] rdata = '0;

   int            total = 0;
   int            passes = 0;
   logic [LB-1:0] last_rline = '0;
   bit            rline_known = 1'b1;

   always #5 clk = ~clk;

   mem_line_burst_adapter #(
      .ADDR_WIDTH     (AW),
      .LINE_SIZE      (LS),
      .BUS_WIDTH      (BW),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .line_addr   (line_addr),
      .line_wdata  (line_wdata),
      .line_rd_req (line_rd_req),
      .line_wr_req (line_wr_req),
      .line_rdata  (line_rdata),
      .line_ready  (line_ready),
      .line_err    (line_err),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .wvalid      (wvalid),
      .wready      (wready),
      .wdata       (wdata),
      .rvalid      (rvalid),
      .rdata       (rdata)
   );

   task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [LB-1:0] rand_line();
      logic [LB-1:0] l;
      for (int i = 0; i < NB; i++) l[i*BW +: BW] = $urandom;
      return l;
   endfunction

   task automatic idle_check();
      @(posedge clk); #1;
      chk("idle_line_ready", line_ready, 1'b0);
      chk("idle_cmd_valid", cmd_valid, 1'b0);
      chk("idle_wvalid", wvalid, 1'b0);
      if (rline_known) chk("rdata_hold", line_rdata, last_rline);
   endtask

   // One full request as seen by the cache side, with the bench acting as
   // memory. gap_mode: 0 = no wait, 1 = ready toggles 1/0, 2 = random.
   task automatic run_burst(input bit wr, input bit rd, input logic [AW-1:0] addr,
                            input logic [LB-1:0] wline, input int cmd_stall,
                            input int gap_mode, input bit idx_data, input int abort_beat,
                            input int stop_beat, input bit keep_rd);
      logic [LB-1:0] model;
      logic [BW-1:0] pend_rd;
      int  k, last_hs, iter, done_iter;
      bit  cmd_done, pend_cmd, pend_beat, done, aborted, timed_out, exp_ready, tog;
      model = '0; pend_rd = '0; k = 0; last_hs = 1; done_iter = 0;
      cmd_done = 0; pend_cmd = 0; pend_beat = 0; done = 0; aborted = 0; tog = 1;
      line_addr = addr; line_wdata = wline; line_wr_req = wr; line_rd_req = rd;
      for (iter = 1; iter <= 600; iter++) begin
         @(posedge clk); #1;
         if (pend_cmd) begin cmd_done = 1; last_hs = iter; end
         if (pend_beat) begin
            if (!wr) model[k*BW +: BW] = pend_rd;
            k++;
            last_hs = iter;
         end
         pend_cmd = 0; pend_beat = 0;
         timed_out = (k != NB) && (iter - last_hs == TO_MODEL);
         exp_ready = (k == NB) || timed_out;
         chk("line_ready", line_ready, exp_ready);
         chk("line_err", line_err, timed_out);
         if (exp_ready) begin
            done = 1; done_iter = iter;
            if (!wr) begin
               if (!timed_out) begin
                  chk("line_rdata", line_rdata, model);
                  last_rline = model; rline_known = 1;
               end else begin
                  rline_known = 0;
               end
            end
            if (cmd_stall == 0 && gap_mode == 0 && !timed_out) chk("latency", iter, 2 + NB);
            line_wr_req = 0; line_rd_req = keep_rd ? rd : 1'b0;
            cmd_ready = 0; wready = 0; rvalid = 1'($urandom); rdata = $urandom;
            break;
         end else if (!cmd_done) begin
            chk("cmd_valid", cmd_valid, 1'b1);
            chk("cmd_write", cmd_write, wr);
            chk("cmd_addr", cmd_addr, addr & ~32'(LS - 1));
            chk("wvalid_in_cmd", wvalid, 1'b0);
            cmd_ready = (iter > cmd_stall);
            pend_cmd = cmd_ready;
            rvalid = 1'($urandom); rdata = $urandom;
         end else begin
            chk("cmd_valid_off", cmd_valid, 1'b0);
            line_addr = $urandom; line_wdata = rand_line();
            if (wr) begin
               chk("wvalid", wvalid, 1'b1);
               chk("wdata", wdata, wline[k*BW +: BW]);
               if (gap_mode == 0) wready = 1;
               else if (gap_mode == 1) begin wready = tog; tog = ~tog; end
               else wready = 1'($urandom);
               pend_beat = wready;
               rvalid = 1'($urandom); rdata = $urandom;
            end else begin
               chk("wvalid_in_read", wvalid, 1'b0);
               if (k == abort_beat) begin
                  rst_n = 0; line_rd_req = 0; rvalid = 0; aborted = 1;
                  break;
               end
               if (stop_beat >= 0 && k >= stop_beat) rvalid = 0;
               else if (gap_mode == 0) rvalid = 1;
               else rvalid = 1'($urandom);
               rdata = idx_data ? BW'(k) : BW'($urandom);
               pend_beat = rvalid; pend_rd = rdata;
            end
         end
      end
      if (aborted) begin
         @(posedge clk); #1;
         chk("rst_line_ready", line_ready, 1'b0);
         chk("rst_line_err", line_err, 1'b0);
         chk("rst_cmd_valid", cmd_valid, 1'b0);
         chk("rst_cmd_write", cmd_write, 1'b0);
         chk("rst_cmd_addr", cmd_addr, '0);
         chk("rst_wvalid", wvalid, 1'b0);
         chk("rst_wdata", wdata, '0);
         chk("rst_line_rdata", line_rdata, '0);
         last_rline = '0; rline_known = 1;
         rst_n = 1;
      end else begin
         chk("burst_done", done, 1'b1);
         if (!done) begin
            line_wr_req = 0; line_rd_req = 0; cmd_ready = 0; wready = 0; rvalid = 0;
         end
      end
      $display("burst %s addr=%08h beats=%0d cycles=%0d aborted=%0d", wr ? "write" : "read",
               addr, k, done_iter, aborted);
   endtask

   initial begin
      logic [LB-1:0] l;
      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_line_ready", line_ready, 1'b0);
      chk("reset_cmd_valid", cmd_valid, 1'b0);
      chk("reset_wvalid", wvalid, 1'b0);
      chk("reset_line_err", line_err, 1'b0);
      chk("reset_line_rdata", line_rdata, '0);
      rst_n = 1;
      idle_check();

      // Zero-wait fetch, beat data equals beat index.
      run_burst(0, 1, 32'h0000_1234, '0, 0, 0, 1, -1, -1, 0);
      idle_check();

      // Writeback with wready toggling, words 0xA0+k.
      for (int i = 0; i < NB; i++) l[i*BW +: BW] = 32'hA0 + i;
      run_burst(1, 0, 32'h0000_8040, l, 0, 1, 0, -1, -1, 0);
      idle_check();

      // Both requests: write first, then the held read after one idle cycle.
      run_burst(1, 1, 32'h0001_00FF, rand_line(), 0, 0, 0, -1, -1, 1);
      idle_check();
      run_burst(0, 1, 32'h0001_00FF, '0, 0, 0, 0, -1, -1, 0);
      idle_check();

      // Command stalled for 10 cycles.
      run_burst(1, 0, 32'hDEAD_BEEF, rand_line(), 10, 0, 0, -1, -1, 0);
      idle_check();

      // Reset mid-read at beat 7, then a fresh fetch.
      run_burst(0, 1, 32'h0000_2000, '0, 0, 0, 0, 7, -1, 0);
      idle_check();
      run_burst(0, 1, 32'h0000_2040, '0, 0, 2, 0, -1, -1, 0);
      idle_check();

      // Randomised bursts.
      for (int n = 0; n < 8; n++) begin
         bit op;
         op = 1'($urandom);
         run_burst(op, ~op, $urandom, rand_line(), $urandom_range(0, 4), 2, 0, -1, -1, 0);
         idle_check();
      end

`ifdef MEM_TIMEOUT_EN
      // Read beats stop after beat 3: error completion 8 cycles later.
      run_burst(0, 1, 32'h0000_3000, '0, 0, 0, 0, -1, 4, 0);
      idle_check();
`endif

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
